instr_fetch_unit: RTL and testbench

// - Fetch stage directly upstream of the control unit: holds PC and instruction register (IR),

---
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds PC and IR, reads instruction memory through a REQ/WAIT handshake
// and stops on END_OPCODE. Optional fetch timeout under `FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned INSTR_W    = 24,
  parameter int unsigned OPCODE_W   = 6,
  parameter int unsigned END_OPCODE = 25
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_req,
  input  logic                         pc_load,
  input  logic [ADDR_W-1:0]            pc_load_addr,
  output logic [ADDR_W-1:0]            imem_addr,
  output logic                         imem_rd_en,
  input  logic [INSTR_W-1:0]           imem_rdata,
  input  logic                         imem_valid,
  output logic [OPCODE_W-1:0]          instruction_opcode,
  output logic [INSTR_W-OPCODE_W-1:0]  operand,
  output logic                         instr_valid,
  output logic                         busy,
  output logic                         halted,
  output logic                         fetch_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               instr_valid_q, instr_valid_d;
  logic               rdata_is_end;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [4:0] TO_LAST = 5'(TIMEOUT_CYC - 1);
  logic [4:0] cnt_q, cnt_d;
  logic       fetch_err_q, fetch_err_d;
`endif

  assign rdata_is_end = (imem_rdata[INSTR_W-1 -: OPCODE_W] == OPCODE_W'(END_OPCODE));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    instr_valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d       = cnt_q;
    fetch_err_d = fetch_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A simultaneous load and request fetches from the newly loaded PC.
        if (pc_load)   pc_d    = pc_load_addr;
        if (fetch_req) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (imem_valid) begin
          ir_d          = imem_rdata;
          pc_d          = pc_q + ADDR_W'(1);
          instr_valid_d = 1'b1;
          state_d       = rdata_is_end ? S_HALT : S_IDLE;
        end
`ifdef FETCH_TIMEOUT_EN
        // Data arriving on the final count cycle takes priority over the timeout.
        else if (cnt_q == TO_LAST) begin
          fetch_err_d = 1'b1;
          state_d     = S_HALT;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      ir_q          <= '0;
      instr_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q       <= '0;
      fetch_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      instr_valid_q <= instr_valid_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q       <= cnt_d;
      fetch_err_q <= fetch_err_d;
`endif
    end
  end

  assign imem_addr          = pc_q;
  assign imem_rd_en         = (state_q == S_REQ);
  assign instruction_opcode = ir_q[INSTR_W-1 -: OPCODE_W];
  assign operand            = ir_q[INSTR_W-OPCODE_W-1:0];
  assign instr_valid        = instr_valid_q;
  assign busy               = (state_q == S_REQ) || (state_q == S_WAIT);
  assign halted             = (state_q == S_HALT);
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table of fetch vectors plus hand-written
// sequences for reset, ignored inputs, stray valid, timeout and halt.
module tb_instr_fetch_unit;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned INSTR_W = 24;
  localparam int unsigned OPCODE_W = 6;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        fetch_req = 1'b0;
  logic                        pc_load = 1'b0;
  logic [ADDR_W-1:0]           pc_load_addr = '0;
  logic [ADDR_W-1:0]           imem_addr;
  logic                        imem_rd_en;
  logic [INSTR_W-1:0]          imem_rdata;
  logic                        imem_valid;
  logic [OPCODE_W-1:0]         instruction_opcode;
  logic [INSTR_W-OPCODE_W-1:0] operand;
  logic                        instr_valid;
  logic                        busy;
  logic                        halted;
  logic                        fetch_err;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .OPCODE_W(OPCODE_W), .END_OPCODE(25)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .instruction_opcode(instruction_opcode), .operand(operand), .instr_valid(instr_valid),
    .busy(busy), .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Memory model: answers a read strobe 'lat' cycles later with a one-cycle valid.
  logic [INSTR_W-1:0] mem [256];
  int unsigned        lat = 1;
  logic               mem_en = 1'b1;
  int unsigned        cd = 0;
  logic [ADDR_W-1:0]  raddr = '0;
  logic               m_valid = 1'b0;
  logic [INSTR_W-1:0] m_data = '0;
  logic               s_valid = 1'b0;
  logic [INSTR_W-1:0] s_data = '0;
  int unsigned        rd_cnt = 0;

  assign imem_valid = m_valid | s_valid;
  assign imem_rdata = s_valid ? s_data : m_data;

  always @(negedge clk) begin
    m_valid = 1'b0;
    if (imem_rd_en) begin
      rd_cnt++;
      cd    = lat;
      raddr = imem_addr;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0 && mem_en) begin
        m_valid = 1'b1;
        m_data  = mem[raddr];
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ld;
    logic [7:0]  ld_addr;
    logic [5:0]  op;
    logic [17:0] opnd;
    logic [7:0]  req_addr;
    logic [7:0]  pc_after;
    logic        halt;
  } vec_t;

  task automatic fetch_and_check(input vec_t v);
    int n;
    @(negedge clk);
    fetch_req = 1'b1; pc_load = v.ld; pc_load_addr = v.ld_addr;
    @(negedge clk);
    fetch_req = 1'b0; pc_load = 1'b0;
    chk("rd_en_in_req", imem_rd_en, 1);
    chk("addr_in_req", imem_addr, v.req_addr);
    n = 1;
    while (!instr_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 2 + lat);
    chk("opcode", instruction_opcode, v.op);
    chk("operand", operand, v.opnd);
    chk("pc_after", imem_addr, v.pc_after);
    chk("halted", halted, v.halt);
    chk("busy_after", busy, 0);
    @(negedge clk);
    chk("valid_pulse_1cyc", instr_valid, 0);
    chk("opcode_stable", instruction_opcode, v.op);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t vhalt;
    int unsigned base;
    int n;
    int bad;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0]    = 24'h040001;
    mem[1]    = 24'h080002;
    mem[2]    = 24'h0C0042;
    mem[3]    = 24'h640123;
    mem[8'h10] = 24'hFFFFFF;
    mem[8'hFF] = 24'h0C00AB;

    vecs[0] = '{ld:1'b0, ld_addr:8'h00, op:6'd1,  opnd:18'h00001, req_addr:8'h00, pc_after:8'h01, halt:1'b0};
    vecs[1] = '{ld:1'b0, ld_addr:8'h00, op:6'd2,  opnd:18'h00002, req_addr:8'h01, pc_after:8'h02, halt:1'b0};
    vecs[2] = '{ld:1'b1, ld_addr:8'h10, op:6'd63, opnd:18'h3FFFF, req_addr:8'h10, pc_after:8'h11, halt:1'b0};
    vecs[3] = '{ld:1'b1, ld_addr:8'hFF, op:6'd3,  opnd:18'h000AB, req_addr:8'hFF, pc_after:8'h00, halt:1'b0};
    vecs[4] = '{ld:1'b0, ld_addr:8'h00, op:6'd1,  opnd:18'h00001, req_addr:8'h00, pc_after:8'h01, halt:1'b0};
    vhalt   = '{ld:1'b1, ld_addr:8'h03, op:6'd25, opnd:18'h00123, req_addr:8'h03, pc_after:8'h04, halt:1'b1};

    // Reset held with a pending request: everything stays zero.
    fetch_req = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if ({imem_addr, imem_rd_en, instruction_opcode, operand, instr_valid, busy, halted, fetch_err} !== '0)
        bad++;
    end
    chk("reset_outputs_zero", bad, 0);
    chk("reset_no_rd_en", rd_cnt, 0);
    fetch_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_pc", imem_addr, 0);
    chk("post_reset_busy", busy, 0);

    lat = 1;
    for (int i = 0; i < 5; i++) fetch_and_check(vecs[i]);

    // fetch_req/pc_load during WAIT must be ignored (4-cycle memory, PC=1).
    lat = 4;
    base = rd_cnt;
    @(negedge clk); fetch_req = 1'b1;
    @(negedge clk); fetch_req = 1'b0;
    @(negedge clk); fetch_req = 1'b1; pc_load = 1'b1; pc_load_addr = 8'h55;
    @(negedge clk); fetch_req = 1'b0; pc_load = 1'b0;
    chk("wait_pc_unchanged", imem_addr, 8'h01);
    chk("wait_busy", busy, 1);
    n = 0;
    while (!instr_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ign_opcode", instruction_opcode, 2);
    chk("ign_pc", imem_addr, 8'h02);
    repeat (4) @(negedge clk);
    chk("ign_single_rd", rd_cnt - base, 1);
    chk("ign_idle", busy, 0);

    // Stray valid in IDLE leaves IR alone.
    s_data = 24'hFC0000;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    chk("stray_valid_ir", instruction_opcode, 2);
    chk("stray_valid_pulse", instr_valid, 0);

`ifdef FETCH_TIMEOUT_EN
    lat = 16;
    fetch_and_check('{ld:1'b0, ld_addr:8'h00, op:6'd3, opnd:18'h00042, req_addr:8'h02, pc_after:8'h03, halt:1'b0});
    chk("valid_wins_no_err", fetch_err, 0);
    mem_en = 1'b0;
    @(negedge clk); fetch_req = 1'b1;
    @(negedge clk); fetch_req = 1'b0;
    n = 1;
    while (!halted && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 18);
    chk("timeout_err", fetch_err, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_pc", imem_addr, 8'h03);
    chk("timeout_ir", instruction_opcode, 3);
`else
    mem_en = 1'b0;
    @(negedge clk); fetch_req = 1'b1;
    @(negedge clk); fetch_req = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b1 || fetch_err !== 1'b0 || halted !== 1'b0) bad++;
    end
    chk("no_timeout_busy", bad, 0);
`endif
    mem_en = 1'b1;

    // Asynchronous reset between edges, then mid-fetch with a late valid.
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_state", {imem_addr, instruction_opcode, halted, fetch_err}, 0);
    @(negedge clk); rst = 1'b1;
    lat = 4;
    @(negedge clk); fetch_req = 1'b1;
    @(negedge clk); fetch_req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midfetch_rst_busy", busy, 0);
    chk("midfetch_rst_rd", imem_rd_en, 0);
    @(negedge clk); rst = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (instr_valid !== 1'b0 || instruction_opcode !== '0 || imem_addr !== '0 || busy !== 1'b0) bad++;
    end
    chk("late_valid_ignored", bad, 0);

    // END opcode halts; further requests produce no reads.
    lat = 1;
    fetch_and_check(vhalt);
    base = rd_cnt;
    fetch_req = 1'b1; pc_load = 1'b1; pc_load_addr = 8'h00;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (instr_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b1) bad++;
    end
    fetch_req = 1'b0; pc_load = 1'b0;
    chk("halt_outputs", bad, 0);
    chk("halt_no_rd", rd_cnt - base, 0);
    chk("halt_pc_frozen", imem_addr, 8'h04);
    chk("halt_ir_frozen", instruction_opcode, 25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
